// File: rtl/fp_mul_pipe.sv
// Pipelined IEEE-style floating-point multiplier, flush-to-zero, five rounding modes, valid/ready.
// Optional sticky flag accumulation is enabled by defining FP_MUL_STICKY_FLAGS_EN.
module fp_mul_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRC_W  = 23,
  parameter int STAGES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+FRC_W:0]   fp_X,
  input  logic [EXP_W+FRC_W:0]   fp_Y,
  input  logic [2:0]             r_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+FRC_W:0]   fp_Z,
  output logic                   ovrf,
  output logic                   udrf
`ifdef FP_MUL_STICKY_FLAGS_EN
  ,
  input  logic                   clr_flags,
  output logic                   ovrf_sticky,
  output logic                   udrf_sticky
`endif
);
  localparam int W  = 1 + EXP_W + FRC_W;
  localparam int MW = FRC_W + 1;
  localparam int PW = 2 * MW;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EONE = EW'(1);
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;

  typedef struct packed {
    logic          sign;
    logic          spec;
    logic [W-1:0]  spec_z;
    logic [EW-1:0] expo;
    logic [MW-1:0] mx;
    logic [MW-1:0] my;
    logic [2:0]    mode;
  } a_t;

  typedef struct packed {
    logic          sign;
    logic          spec;
    logic [W-1:0]  spec_z;
    logic [EW-1:0] expo;
    logic [PW-1:0] prod;
    logic [2:0]    mode;
  } b_t;

  typedef struct packed {
    logic [W-1:0] z;
    logic         ovrf;
    logic         udrf;
  } c_t;

  // Modes 101..111 fall into the default arm and behave as round-to-nearest-even.
  function automatic logic round_up(input logic [2:0] mode, input logic sign, input logic lsb,
                                    input logic g, input logic r, input logic s);
    case (mode)
      3'b001:  round_up = 1'b0;
      3'b010:  round_up = sign & (g | r | s);
      3'b011:  round_up = ~sign & (g | r | s);
      3'b100:  round_up = g;
      default: round_up = g & (r | s | lsb);
    endcase
  endfunction

  function automatic logic [W-1:0] sat_result(input logic [2:0] mode, input logic sign);
    logic to_inf;
    case (mode)
      3'b001:  to_inf = 1'b0;
      3'b010:  to_inf = sign;
      3'b011:  to_inf = ~sign;
      default: to_inf = 1'b1;
    endcase
    sat_result = to_inf ? {sign, EXP_ONES, {FRC_W{1'b0}}}
                        : {sign, {(EXP_W-1){1'b1}}, 1'b0, {FRC_W{1'b1}}};
  endfunction

  logic             advance;
  logic [EXP_W-1:0] ex, ey;
  logic [FRC_W-1:0] fx, fy;
  logic             x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
  a_t               a_c, a_s;
  b_t               b_c, b_s;
  c_t               c_c, c_p2, c_out;
  logic             vld_a, vld_b, vld_p2, vld_out;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Unpack, classify, exponent add
  assign ex     = fp_X[W-2 -: EXP_W];
  assign ey     = fp_Y[W-2 -: EXP_W];
  assign fx     = fp_X[FRC_W-1:0];
  assign fy     = fp_Y[FRC_W-1:0];
  assign x_zero = (ex == '0);
  assign y_zero = (ey == '0);
  assign x_inf  = (ex == EXP_ONES) && (fx == '0);
  assign y_inf  = (ey == EXP_ONES) && (fy == '0);
  assign x_nan  = (ex == EXP_ONES) && (fx != '0);
  assign y_nan  = (ey == EXP_ONES) && (fy != '0);

  always_comb begin
    a_c.sign   = fp_X[W-1] ^ fp_Y[W-1];
    a_c.mode   = r_mode;
    a_c.expo   = $signed({2'b00, ex}) + $signed({2'b00, ey}) - BIAS;
    a_c.mx     = {1'b1, fx};
    a_c.my     = {1'b1, fy};
    a_c.spec   = 1'b1;
    a_c.spec_z = '0;
    if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero))
      a_c.spec_z = {1'b0, EXP_ONES, 1'b1, {(FRC_W-1){1'b0}}};
    else if (x_inf || y_inf)
      a_c.spec_z = {a_c.sign, EXP_ONES, {FRC_W{1'b0}}};
    else if (x_zero || y_zero)
      a_c.spec_z = {a_c.sign, {(W-1){1'b0}}};
    else
      a_c.spec = 1'b0;
  end

  generate
    if (STAGES >= 3) begin : g_p0
      a_t   a_p0;
      logic vld_p0;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)       vld_p0 <= 1'b0;
        else if (advance) vld_p0 <= in_valid;
      always_ff @(posedge clk)
        if (advance) a_p0 <= a_c;
      assign a_s   = a_p0;
      assign vld_a = vld_p0;
    end else begin : g_p0_merge
      assign a_s   = a_c;
      assign vld_a = in_valid;
    end
  endgenerate

  // Mantissa multiply
  always_comb begin
    b_c.sign   = a_s.sign;
    b_c.spec   = a_s.spec;
    b_c.spec_z = a_s.spec_z;
    b_c.expo   = a_s.expo;
    b_c.mode   = a_s.mode;
    b_c.prod   = {{MW{1'b0}}, a_s.mx} * {{MW{1'b0}}, a_s.my};
  end

  generate
    if (STAGES >= 2) begin : g_p1
      b_t   b_p1;
      logic vld_p1;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)       vld_p1 <= 1'b0;
        else if (advance) vld_p1 <= vld_a;
      always_ff @(posedge clk)
        if (advance) b_p1 <= b_c;
      assign b_s   = b_p1;
      assign vld_b = vld_p1;
    end else begin : g_p1_merge
      assign b_s   = b_c;
      assign vld_b = vld_a;
    end
  endgenerate

  // Normalise, round, pack; pn drops the leading one so it holds fraction, guard, round, sticky
  logic                 pmsb, rnd;
  logic [PW-2:0]        pn;
  logic signed [EW-1:0] e_n, e_f;
  logic [FRC_W:0]       frac_r;

  assign pmsb   = b_s.prod[PW-1];
  assign pn     = pmsb ? b_s.prod[PW-2:0] : {b_s.prod[PW-3:0], 1'b0};
  assign e_n    = $signed(b_s.expo) + $signed({{(EW-1){1'b0}}, pmsb});
  assign rnd    = round_up(b_s.mode, b_s.sign, pn[FRC_W+1], pn[FRC_W], pn[FRC_W-1],
                           |pn[FRC_W-2:0]);
  assign frac_r = {1'b0, pn[PW-2 -: FRC_W]} + {{FRC_W{1'b0}}, rnd};
  assign e_f    = e_n + $signed({{(EW-1){1'b0}}, frac_r[FRC_W]});

  always_comb begin
    c_c.z    = {b_s.sign, e_f[EXP_W-1:0], frac_r[FRC_W-1:0]};
    c_c.ovrf = 1'b0;
    c_c.udrf = 1'b0;
    if (b_s.spec) begin
      c_c.z = b_s.spec_z;
    end else if (e_n < EONE) begin
      c_c.z    = {b_s.sign, {(W-1){1'b0}}};
      c_c.udrf = 1'b1;
    end else if (e_f >= EMAX) begin
      c_c.z    = sat_result(b_s.mode, b_s.sign);
      c_c.ovrf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      c_p2   <= '0;
    end else if (advance) begin
      vld_p2 <= vld_b;
      c_p2   <= c_c;
    end

  generate
    if (STAGES >= 4) begin : g_p3
      c_t   c_p3;
      logic vld_p3;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          vld_p3 <= 1'b0;
          c_p3   <= '0;
        end else if (advance) begin
          vld_p3 <= vld_p2;
          c_p3   <= c_p2;
        end
      assign c_out   = c_p3;
      assign vld_out = vld_p3;
    end else begin : g_p3_none
      assign c_out   = c_p2;
      assign vld_out = vld_p2;
    end
  endgenerate

  assign out_valid = vld_out;
  assign fp_Z      = c_out.z;
  assign ovrf      = c_out.ovrf;
  assign udrf      = c_out.udrf;

`ifdef FP_MUL_STICKY_FLAGS_EN
  // A clear and a same-cycle set resolve in favour of the set.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ovrf_sticky <= 1'b0;
      udrf_sticky <= 1'b0;
    end else begin
      ovrf_sticky <= (ovrf_sticky & ~clr_flags) | (out_valid & out_ready & ovrf);
      udrf_sticky <= (udrf_sticky & ~clr_flags) | (out_valid & out_ready & udrf);
    end
`else
  // Flags are reported per result only.
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe (single precision, STAGES=3): exact-integer reference model,
// scoreboard with latency/stall tracking, directed vectors, back-pressure, reset, random traffic.
module tb_fp_mul_pipe;
  localparam int STG = 3;

  logic        clk = 1'b0, rst_n = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, ovrf, udrf;
  logic [31:0] fp_X = '0, fp_Y = '0, fp_Z;
  logic [2:0]  r_mode = '0;

  fp_mul_pipe #(.EXP_W(8), .FRC_W(23), .STAGES(STG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fp_X(fp_X), .fp_Y(fp_Y), .r_mode(r_mode), .out_valid(out_valid),
    .out_ready(out_ready), .fp_Z(fp_Z), .ovrf(ovrf), .udrf(udrf));

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0, stalls = 0;

  typedef struct { logic [33:0] v; int acc; int st; } item_t;
  item_t sb[$];
  item_t it;
  logic [33:0] held;
  logic        hold_vld = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: exact 48-bit significand product, rounded by comparing the remainder to half an ulp.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
    logic s, up, to_inf;
    int ex, ey, be, msb, shift;
    longint unsigned a, b, mp, q, rem, half;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0) ||
        (ex == 255 && ey == 0) || (ey == 255 && ex == 0))
      return {32'h7FC00000, 2'b00};
    if (ex == 255 || ey == 255) return {s, 8'hFF, 23'h0, 2'b00};
    if (ex == 0 || ey == 0)     return {s, 31'h0, 2'b00};
    a     = {40'h0, 1'b1, x[22:0]};
    b     = {40'h0, 1'b1, y[22:0]};
    mp    = a * b;
    msb   = mp[47] ? 47 : 46;
    shift = msb - 23;
    q     = mp >> shift;
    rem   = mp & ((64'd1 << shift) - 64'd1);
    half  = 64'd1 << (shift - 1);
    be    = ex + ey - 127 + (msb - 46);
    if (be < 1) return {s, 31'h0, 2'b01};
    case (m)
      3'd1:    up = 1'b0;
      3'd2:    up = s && (rem != 0);
      3'd3:    up = !s && (rem != 0);
      3'd4:    up = (rem >= half);
      default: up = (rem > half) || (rem == half && q[0]);
    endcase
    q = q + 64'(up);
    if (q == (64'd1 << 24)) begin
      q  = q >> 1;
      be = be + 1;
    end
    if (be >= 255) begin
      case (m)
        3'd1:    to_inf = 1'b0;
        3'd2:    to_inf = s;
        3'd3:    to_inf = !s;
        default: to_inf = 1'b1;
      endcase
      return to_inf ? {s, 8'hFF, 23'h0, 2'b10} : {s, 8'hFE, 23'h7FFFFF, 2'b10};
    end
    return {s, be[7:0], q[22:0], 2'b00};
  endfunction

  // Scoreboard, latency and stall-stability checks, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) check("stall_hold", {31'h0, out_valid, fp_Z, ovrf, udrf}, {31'h0, 1'b1, held});
      if (in_valid && in_ready) sb.push_back('{model(fp_X, fp_Y, r_mode), cyc, stalls});
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out", {63'h0, out_valid}, 64'h0);
        end else if (out_ready) begin
          it = sb.pop_front();
          check("result", {30'h0, fp_Z, ovrf, udrf}, {30'h0, it.v});
          check("latency", 64'(cyc), 64'(it.acc + STG + (stalls - it.st)));
        end else begin
          stalls++;
          check("in_ready_stall", {63'h0, in_ready}, 64'h0);
        end
      end
      hold_vld = out_valid && !out_ready;
      held     = {fp_Z, ovrf, udrf};
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
    int   n = 0;
    logic acc;
    fp_X = x; fp_Y = y; r_mode = m; in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at %b, expected 1", in_ready);
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_op();
    int k;
    logic [7:0]  e;
    logic [22:0] f;
    k = $urandom_range(0, 9);
    f = 23'($urandom);
    if (k == 0)      e = 8'h00;
    else if (k == 1) begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = '0; end
    else if (k < 6)  e = 8'($urandom_range(100, 154));
    else             e = 8'($urandom_range(1, 254));
    k = $urandom_range(0, 7);
    if (k == 0) f = '0;
    if (k == 1) f = 23'h7FFFFF;
    return {1'($urandom), e, f};
  endfunction

  logic [31:0] vx [12] = '{32'h40400000, 32'h3F800001, 32'h3F800001, 32'h00000001,
                            32'h80400000, 32'h7F000000, 32'h7F000000, 32'hFF000000,
                            32'h00800000, 32'h7F800000, 32'h7FC00000, 32'hBF800001};
  logic [31:0] vy [12] = '{32'h40000000, 32'h3F800001, 32'h3F800001, 32'h3F800000,
                            32'h3F800000, 32'h40000000, 32'h40000000, 32'h40000000,
                            32'h3F000000, 32'h00000000, 32'h3F800000, 32'h3F800001};
  logic [2:0]  vm [12] = '{3'd0, 3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd1, 3'd3, 3'd0, 3'd0, 3'd0, 3'd2};
  logic [33:0] ve [12] = '{{32'h40C00000, 2'b00}, {32'h3F800002, 2'b00}, {32'h3F800003, 2'b00},
                            {32'h00000000, 2'b00}, {32'h80000000, 2'b00}, {32'h7F800000, 2'b10},
                            {32'h7F7FFFFF, 2'b10}, {32'hFF7FFFFF, 2'b10}, {32'h00000000, 2'b01},
                            {32'h7FC00000, 2'b00}, {32'h7FC00000, 2'b00}, {32'hBF800003, 2'b00}};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    int n;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_fp_Z", {32'h0, fp_Z}, 64'h0);
    check("rst_flags", {62'h0, ovrf, udrf}, 64'h0);
    check("rst_in_ready", {63'h0, in_ready}, 64'h1);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) check($sformatf("model_pin%0d", i), {30'h0, model(vx[i], vy[i], vm[i])}, {30'h0, ve[i]});

    // Directed vectors through the pipe, free-flowing output
    for (int i = 0; i < 12; i++) send(vx[i], vy[i], vm[i]);
    n = 0;
    while (sb.size() != 0 && n < 100) begin @(posedge clk); n++; end
    #1 check("drain_directed", 64'(sb.size()), 64'h0);

    // Back-pressure: four accepts, output held for five cycles once the first result shows
    fork
      begin
        send(32'h40400000, 32'h40000000, 3'd0);
        send(32'h3F800001, 32'h3F800001, 3'd3);
        send(32'h7F000000, 32'h40000000, 3'd1);
        send(32'h00800000, 32'h3F000000, 3'd0);
      end
      begin
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!out_valid && n < 20);
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    n = 0;
    while (sb.size() != 0 && n < 100) begin @(posedge clk); n++; end
    #1 check("drain_backpressure", 64'(sb.size()), 64'h0);

    // Reset in the middle of a stream drops everything in flight
    send(32'h40400000, 32'h40000000, 3'd0);
    send(32'h3FC00000, 32'h3FC00000, 3'd0);
    send(32'hC0000000, 32'h40400000, 3'd0);
    rst_n = 1'b0;
    #1 check("midrst_out_valid", {63'h0, out_valid}, 64'h0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_idle", {63'h0, out_valid}, 64'h0);
    end

    // Random traffic with random gaps and random back-pressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send(rand_op(), rand_op(), 3'($urandom_range(0, 7)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 200) begin @(posedge clk); n++; end
    #1 check("drain_random", 64'(sb.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp_mul_pipe.md
# fp_mul_pipe

Pipelined, parametrised floating-point multiplier with a valid/ready handshake, five rounding modes and flush-to-zero subnormal handling. It is the sequential successor of the combinational single-precision multiplier in the ALU: same `fp_X`/`fp_Y`/`fp_Z`/`r_mode`/`ovrf`/`udrf` contract, generalised to any IEEE-style format. It adds configurable latency and back-pressure so it can sit between the FPU issue stage and the writeback arbiter.

## Interface
- `EXP_W`, default 8: exponent width; BIAS = 2^(EXP_W-1)-1.
- `FRC_W`, default 23: stored fraction width. Operand width W = 1+EXP_W+FRC_W.
- `STAGES`, default 3, legal 1..4: register stages from operand accept to `out_valid`.
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: operands and `r_mode` valid.
- `in_ready`, out, 1: block accepts operands this cycle.
- `fp_X`, `fp_Y`, in, W: operands.
- `r_mode`, in, 3: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 behave as RNE.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accepts result.
- `fp_Z`, out, W: product.
- `ovrf`, `udrf`, out, 1: overflow and underflow flags, qualified by `out_valid`.

## Operation
- Classify each operand:
  - exp==0: zero. Subnormals are flushed to signed zero; the flush itself raises no flag.
  - exp all-ones, frac==0: Inf.
  - exp all-ones, frac!=0: NaN.
- Special cases, in priority order:
  - any NaN, or Inf×zero: canonical qNaN (sign 0, exp all-ones, frac MSB 1, rest 0); flags 0.
  - Inf×finite-nonzero or Inf×Inf: Inf with sign = sX^sY; flags 0.
  - zero×finite: zero with sign sX^sY; flags 0.
- Normal path:
  - E = eX+eY−BIAS in signed EXP_W+2 bits.
  - P = {1,fX}×{1,fY}, 2·(FRC_W+1) bits. If P MSB is set, shift right 1 and E+1.
  - Guard, round and sticky bits come from the discarded low bits. Round per `r_mode` using the result sign.
  - Mantissa carry-out on rounding shifts right and sets E+1.
- Underflow: if the normalised, unrounded E < 1, output signed zero and set `udrf`=1 (tininess is detected before rounding).
- Overflow: if the final E ≥ 2^EXP_W−1, set `ovrf`=1. Result by mode:
  - RNE, RMM: ±Inf.
  - RTZ: ±max-finite.
  - RDN: +max-finite or −Inf.
  - RUP: +Inf or −max-finite.
- `ovrf` and `udrf` are never set together.

## Timing
- Accept on `in_valid && in_ready`. The result appears on `out_valid` exactly STAGES cycles later when there is no stall.
- Whole-pipe stall: advance = !`out_valid` || `out_ready`, and `in_ready` = advance (combinational).
- While stalled, `fp_Z`, `ovrf`, `udrf` and `out_valid` hold stable.
- Combinational logic is split as: unpack/classify/exponent add | multiply | normalise/round/pack. With fewer stages, adjacent steps merge. With STAGES=4, an extra output register is added.
- Throughput: 1 per cycle when `out_ready`=1. Results leave in acceptance order, none lost or duplicated.
- Bubbles: when `in_valid`=0 on an advance, an invalid slot enters the pipe.
- Reset (async assert, sync-safe deassert): all valid bits, `fp_Z`, `ovrf` and `udrf` go to 0. `in_ready`=1 after reset. Reset mid-operation discards all in-flight results.

## Configuration
- `FP_MUL_STICKY_FLAGS_EN` defined:
  - adds input `clr_flags` and outputs `ovrf_sticky`, `udrf_sticky` (reset 0).
  - Each sticky flag ORs in `ovrf`/`udrf` on every `out_valid && out_ready` handshake.
  - `clr_flags`=1 clears them next cycle. If clear and set happen in the same cycle, the set wins.
- Undefined: those ports and registers do not exist; the flags are per-result only.

## Test plan
- STAGES=3, RNE:
  - 0x40400000×0x40000000 → 0x40C00000, flags 0, `out_valid` 3 cycles after accept.
  - 0x3F800001×0x3F800001 → 0x3F800002 under RNE, 0x3F800003 under RUP.
- 0x00000001×0x3F800000 → 0x00000000, `udrf`=0. 0x80400000×0x3F800000 → 0x80000000.
- 0x7F000000×0x40000000:
  - RNE → 0x7F800000, `ovrf`=1.
  - RTZ → 0x7F7FFFFF, `ovrf`=1.
  - The same product with sign flipped (0xFF000000×0x40000000) under RUP → 0xFF7FFFFF.
- 0x00800000×0x3F000000 → 0x00000000, `udrf`=1. 0x7F800000×0x00000000 → 0x7FC00000. 0x7FC00000×0x3F800000 → 0x7FC00000.
- Back-pressure: 4 back-to-back accepts, with `out_ready`=0 for 5 cycles starting when the first result is valid. `in_ready` deasserts; after release, all 4 results appear in order with outputs stable during the stall. Asserting `rst_n`=0 mid-stream → `out_valid`=0 immediately, and no stale result appears after release.
